div_share_arbiter: RTL and testbench

Shares one iterative 32-bit radix-2 divider between the two issue lines of the dual-issue execute stage. Line1 carries the older instruction and wins same-cycle contention. The block sequences the divide with an IDLE/CALC/DONE state machine and returns the result to the owning line through a valid/ack handshake. An exception flush aborts any division in flight.

---
 rtl/div_share_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Iterative 32-bit radix-2 divider shared by two issue lines; line1 (older) wins contention.
// Optional DIV_ZERO_FAST_EN: a divide by zero skips the CALC phase and completes in one cycle.
`timescale 1ns/1ps

module div_share_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        excep_flush_i,
    input  logic        line1_req_i,
    input  logic        line2_req_i,
    input  logic        line1_signed_i,
    input  logic        line2_signed_i,
    input  logic [31:0] line1_src1_i,
    input  logic [31:0] line2_src1_i,
    input  logic [31:0] line1_src2_i,
    input  logic [31:0] line2_src2_i,
    input  logic        line1_ack_i,
    input  logic        line2_ack_i,
    output logic        line1_grant_o,
    output logic        line2_grant_o,
    output logic        line1_res_valid_o,
    output logic        line2_res_valid_o,
    output logic [31:0] res_quot_o,
    output logic [31:0] res_rem_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0: line1, 1: line2
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
    logic [31:0] quot_q, quot_d;     // dividend magnitude shifting out, quotient shifting in
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] prem_q, prem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] res_quot_q, res_quot_d;
    logic [31:0] res_rem_q, res_rem_d;
    logic        busy_q;

    // Arbitration
    logic        is_idle;
    logic        grant1, grant2, any_grant;
    logic        sel_signed;
    logic [31:0] sel_src1, sel_src2;
    logic [31:0] mag1, mag2;
    logic        owner_ack;

    assign is_idle   = (state_q == StIdle);
    assign grant1    = is_idle & line1_req_i & ~excep_flush_i;
    assign grant2    = is_idle & line2_req_i & ~line1_req_i & ~excep_flush_i;
    assign any_grant = grant1 | grant2;

    assign sel_signed = line1_req_i ? line1_signed_i : line2_signed_i;
    assign sel_src1   = line1_req_i ? line1_src1_i   : line2_src1_i;
    assign sel_src2   = line1_req_i ? line1_src2_i   : line2_src2_i;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign mag1 = (sel_signed & sel_src1[31]) ? (~sel_src1 + 32'd1) : sel_src1;
    assign mag2 = (sel_signed & sel_src2[31]) ? (~sel_src2 + 32'd1) : sel_src2;

    assign owner_ack = owner_q ? line2_ack_i : line1_ack_i;

    // One restoring shift-subtract step
    logic [32:0] prem_shift;
    logic [32:0] prem_diff;
    logic        take;
    logic [31:0] prem_next;
    logic [31:0] quot_next;
    logic [31:0] fin_quot;
    logic [31:0] fin_rem;

    assign prem_shift = {prem_q, quot_q[31]};
    assign prem_diff  = prem_shift - {1'b0, divisor_q};
    assign take       = ~prem_diff[32];
    assign prem_next  = take ? prem_diff[31:0] : prem_shift[31:0];
    assign quot_next  = {quot_q[30:0], take};

    // With a zero divisor the remainder naturally ends up as |src1|, and the sign fix-up
    // below restores src1 as supplied; only the quotient needs forcing.
    assign fin_quot = dz_q    ? 32'hFFFF_FFFF :
                      q_neg_q ? (~quot_next + 32'd1) : quot_next;
    assign fin_rem  = r_neg_q ? (~prem_next + 32'd1) : prem_next;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        prem_d     = prem_q;
        cnt_d      = cnt_q;
        res_quot_d = res_quot_q;
        res_rem_d  = res_rem_q;

        unique case (state_q)
            StIdle: begin
                if (any_grant) begin
                    owner_d   = grant2;
                    q_neg_d   = sel_signed & (sel_src1[31] ^ sel_src2[31]);
                    r_neg_d   = sel_signed & sel_src1[31];
                    dz_d      = (sel_src2 == 32'd0);
                    quot_d    = mag1;
                    divisor_d = mag2;
                    prem_d    = 32'd0;
                    cnt_d     = 6'd0;
                    state_d   = StCalc;
`ifdef DIV_ZERO_FAST_EN
                    if (sel_src2 == 32'd0) begin
                        res_quot_d = 32'hFFFF_FFFF;
                        res_rem_d  = sel_src1;
                        state_d    = StDone;
                    end
`else
`endif
                end
            end
            StCalc: begin
                prem_d = prem_next;
                quot_d = quot_next;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    res_quot_d = fin_quot;
                    res_rem_d  = fin_rem;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (owner_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush discards whatever is in flight, including an unconsumed result.
        if (excep_flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            quot_q     <= 32'd0;
            divisor_q  <= 32'd0;
            prem_q     <= 32'd0;
            cnt_q      <= 6'd0;
            res_quot_q <= 32'd0;
            res_rem_q  <= 32'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            prem_q     <= prem_d;
            cnt_q      <= cnt_d;
            res_quot_q <= res_quot_d;
            res_rem_q  <= res_rem_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign line1_grant_o     = grant1;
    assign line2_grant_o     = grant2;
    assign line1_res_valid_o = (state_q == StDone) & ~owner_q;
    assign line2_res_valid_o = (state_q == StDone) &  owner_q;
    assign res_quot_o        = res_quot_q;
    assign res_rem_o         = res_rem_q;
    assign busy_o            = busy_q;

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(line1_grant_o && line2_grant_o));
    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(line1_res_valid_o && line2_res_valid_o));
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_o == (state_q != StIdle));
`endif

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized self-checking bench for div_share_arbiter against an arithmetic reference model.
`timescale 1ns/1ps

module tb_div_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        excep_flush;
    logic        line1_req, line2_req;
    logic        line1_signed, line2_signed;
    logic [31:0] line1_src1, line2_src1, line1_src2, line2_src2;
    logic        line1_ack, line2_ack;
    logic        line1_grant, line2_grant;
    logic        line1_valid, line2_valid;
    logic [31:0] res_quot, res_rem;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_share_arbiter u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .excep_flush_i     (excep_flush),
        .line1_req_i       (line1_req),
        .line2_req_i       (line2_req),
        .line1_signed_i    (line1_signed),
        .line2_signed_i    (line2_signed),
        .line1_src1_i      (line1_src1),
        .line2_src1_i      (line2_src1),
        .line1_src2_i      (line1_src2),
        .line2_src2_i      (line2_src2),
        .line1_ack_i       (line1_ack),
        .line2_ack_i       (line2_ack),
        .line1_grant_o     (line1_grant),
        .line2_grant_o     (line2_grant),
        .line1_res_valid_o (line1_valid),
        .line2_res_valid_o (line2_valid),
        .res_quot_o        (res_quot),
        .res_rem_o         (res_rem),
        .busy_o            (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 5ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end
    endfunction

    task automatic drive_req(input bit ln, input bit sgn, input logic [31:0] a,
                             input logic [31:0] b);
        if (!ln) begin
            line1_req = 1'b1; line1_signed = sgn; line1_src1 = a; line1_src2 = b;
        end else begin
            line2_req = 1'b1; line2_signed = sgn; line2_src1 = a; line2_src2 = b;
        end
    endtask

    // Present a lone request, check it is granted, drop it; returns at cycle 1.
    task automatic issue(input bit ln, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        drive_req(ln, sgn, a, b);
        #4;
        check_eq({tag, "_grant"}, {31'd0, ln ? line2_grant : line1_grant}, 32'd1);
        check_eq({tag, "_nogrant"}, {31'd0, ln ? line1_grant : line2_grant}, 32'd0);
        step();
        if (!ln) line1_req = 1'b0;
        else     line2_req = 1'b0;
    endtask

    // Wait for the owner's result, check it, hold it for `hold` cycles, then ack.
    // Returns at the sample point of the cycle after the ack.
    task automatic finish_op(input bit ln, input logic [31:0] eq, input logic [31:0] er,
                             input int lat, input int hold, input string tag);
        int k;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            #4;
            if ((ln ? line2_valid : line1_valid) === 1'b1) begin
                k = c;
                break;
            end
            check_eq({tag, "_early_other"}, {31'd0, ln ? line1_valid : line2_valid}, 32'd0);
            step();
        end
        check_eq({tag, "_latency"}, k, lat);
        if (k == 0) begin
            excep_flush = 1'b1;
            step();
            excep_flush = 1'b0;
            #4;
            return;
        end
        check_eq({tag, "_quot"}, res_quot, eq);
        check_eq({tag, "_rem"}, res_rem, er);
        check_eq({tag, "_other_valid"}, {31'd0, ln ? line1_valid : line2_valid}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            if (!ln) line2_ack = 1'b1;
            else     line1_ack = 1'b1;
            step();
            #4;
            check_eq({tag, "_hold_valid"}, {31'd0, ln ? line2_valid : line1_valid}, 32'd1);
            check_eq({tag, "_hold_quot"}, res_quot, eq);
            check_eq({tag, "_hold_rem"}, res_rem, er);
        end
        line1_ack = 1'b0;
        line2_ack = 1'b0;
        if (!ln) line1_ack = 1'b1;
        else     line2_ack = 1'b1;
        step();
        line1_ack = 1'b0;
        line2_ack = 1'b0;
        #4;
        check_eq({tag, "_valid_drop"}, {31'd0, ln ? line2_valid : line1_valid}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input bit ln, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] q, r;
        int          lat;
        ref_div(sgn, a, b, q, r);
        lat = 33;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        issue(ln, sgn, a, b, tag);
        finish_op(ln, q, r, lat, hold, tag);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [31:0] a, b;
        bit          ln, sgn;

        rst_n = 1'b0; excep_flush = 1'b0;
        line1_req = 1'b0; line2_req = 1'b0; line1_signed = 1'b0; line2_signed = 1'b0;
        line1_src1 = '0; line2_src1 = '0; line1_src2 = '0; line2_src2 = '0;
        line1_ack = 1'b0; line2_ack = 1'b0;
        repeat (3) step();
        #4;
        check_eq("rst_quot", res_quot, 32'd0);
        check_eq("rst_rem", res_rem, 32'd0);
        check_eq("rst_valids", {30'd0, line1_valid, line2_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op(1'b0, 1'b0, 32'd100, 32'd7, 0, "udiv");

        // Contention: line1 signed -100/7 wins, line2 holds its request.
        drive_req(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        drive_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd16);
        #4;
        check_eq("cont_g1", {31'd0, line1_grant}, 32'd1);
        check_eq("cont_g2", {31'd0, line2_grant}, 32'd0);
        step();
        line1_req = 1'b0;
        #4;
        check_eq("cont_g2_calc", {31'd0, line2_grant}, 32'd0);
        step();
        finish_op(1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32, 0, "cont1");
        check_eq("cont_g2_late", {31'd0, line2_grant}, 32'd1);
        step();
        line2_req = 1'b0;
        finish_op(1'b1, 32'h0FFF_FFFF, 32'd15, 33, 0, "cont2");
        step();

        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "ovf");
        run_op(1'b0, 1'b0, 32'd5, 32'd0, 2, "dz");
        run_op(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, 0, "dz_neg");
        run_op(1'b0, 1'b1, 32'd1234567, 32'hFFFF_FFF9, 5, "held");

        // Flush mid-CALC: busy drops next cycle and no result ever appears.
        issue(1'b0, 1'b0, 32'd1000, 32'd3, "fl");
        repeat (9) step();
        excep_flush = 1'b1;
        line2_req   = 1'b1;
        #4;
        check_eq("fl_g2", {31'd0, line2_grant}, 32'd0);
        check_eq("fl_busy_before", {31'd0, busy}, 32'd1);
        step();
        excep_flush = 1'b0;
        line2_req   = 1'b0;
        #4;
        check_eq("fl_busy_after", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            #4;
            seen = seen | line1_valid | line2_valid;
        end
        check_eq("fl_no_valid", {31'd0, seen}, 32'd0);
        step();

        // Request together with flush in IDLE is not granted.
        line1_req   = 1'b1;
        excep_flush = 1'b1;
        #4;
        check_eq("fl_idle_g1", {31'd0, line1_grant}, 32'd0);
        step();
        line1_req   = 1'b0;
        excep_flush = 1'b0;
        #4;
        check_eq("fl_idle_busy", {31'd0, busy}, 32'd0);
        step();

        // Flush in DONE discards the result.
        issue(1'b0, 1'b0, 32'd77, 32'd5, "fd");
        repeat (32) step();
        #4;
        check_eq("fd_valid", {31'd0, line1_valid}, 32'd1);
        excep_flush = 1'b1;
        line1_ack   = 1'b1;
        step();
        excep_flush = 1'b0;
        line1_ack   = 1'b0;
        #4;
        check_eq("fd_valid_drop", {31'd0, line1_valid}, 32'd0);
        check_eq("fd_busy", {31'd0, busy}, 32'd0);
        step();

        // Reset during CALC.
        issue(1'b1, 1'b1, 32'hDEAD_BEEF, 32'd13, "rc");
        repeat (5) step();
        rst_n = 1'b0;
        step();
        #4;
        check_eq("rc_quot", res_quot, 32'd0);
        check_eq("rc_rem", res_rem, 32'd0);
        check_eq("rc_valids", {30'd0, line1_valid, line2_valid}, 32'd0);
        check_eq("rc_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 30; i++) begin
            ln  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(ln, sgn, a, b, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
